memory_arbiter: RTL

Shares the single main-memory port between the fetch stage's instruction interface and the memory stage's data interface.
- Fixed priority to data accesses, with a starvation guard so fetch always makes progress.
- Sits between the pipeline stages and main memory.
- Exactly one transaction is outstanding at a time; it is held until mem_ack.

---
 rtl/memory_arbiter_pkg.sv | 19 +
 rtl/memory_arbiter_if.sv | 45 ++++
 rtl/memory_arbiter_arb_priority.sv | 22 ++
 rtl/memory_arbiter.sv | 116 +++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int BURST_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D
    } arb_state_e;

    function automatic logic [BURST_CNT_W-1:0] burst_inc(
        input logic [BURST_CNT_W-1:0] cnt,
        input logic [BURST_CNT_W-1:0] max_cnt
    );
        return (cnt >= max_cnt) ? max_cnt : cnt + BURST_CNT_W'(1);
    endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Bus bundle between fetch stage, memory stage, arbiter and main memory.
interface memory_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              instr_req;
    logic [ADDR_W-1:0] instr_addr;
    logic              instr_ack;
    logic [31:0]       instr_rdata;

    logic              data_req;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic [3:0]        data_wstrb;
    logic              data_ack;
    logic [31:0]       data_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    logic              busy;

    // slave: the arbiter's view; master: pipeline stages plus main memory
    modport slave (
        input  instr_req, instr_addr,
        input  data_req, data_we, data_addr, data_wdata, data_wstrb,
        input  mem_ack, mem_rdata,
        output instr_ack, instr_rdata, data_ack, data_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, busy
    );

    modport master (
        output instr_req, instr_addr,
        output data_req, data_we, data_addr, data_wdata, data_wstrb,
        output mem_ack, mem_rdata,
        input  instr_ack, instr_rdata, data_ack, data_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, busy
    );

endinterface

// File: rtl/memory_arbiter_arb_priority.sv
// Winner select: data first, unless fetch has waited out a full data burst.
module arb_priority
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_BURST = 4
) (
    input  logic                   instr_req,
    input  logic                   data_req,
    input  logic [BURST_CNT_W-1:0] burst_cnt,
    output logic                   grant_i,
    output logic                   grant_d
);

    logic starve;

    always_comb begin
        starve  = instr_req && (burst_cnt == BURST_CNT_W'(MAX_DATA_BURST));
        grant_d = data_req && !starve;
        grant_i = instr_req && !grant_d;
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one main-memory port between fetch and data; one transaction in flight.
module memory_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_BURST = 4,
    parameter int ADDR_W         = 32
) (
    input logic              clk,
    input logic              rst,
    memory_arbiter_if.slave  bus
);

    arb_state_e             state_q;
    arb_state_e             state_d;
    logic [BURST_CNT_W-1:0] burst_cnt;
    logic                   grant_i;
    logic                   grant_d;
    logic [ADDR_W-1:0]      addr_mux;

    arb_priority #(
        .MAX_DATA_BURST(MAX_DATA_BURST)
    ) u_priority (
        .instr_req(bus.instr_req),
        .data_req (bus.data_req),
        .burst_cnt(burst_cnt),
        .grant_i  (grant_i),
        .grant_d  (grant_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = GRANT_D;
                end else if (grant_i) begin
                    state_d = GRANT_I;
                end
            end
            GRANT_I, GRANT_D: begin
                if (bus.mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_req   = 1'b0;
        bus.busy      = 1'b0;
        bus.mem_we    = 1'b0;
        addr_mux      = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        bus.instr_ack = 1'b0;
        bus.data_ack  = 1'b0;
        case (state_q)
            GRANT_I: begin
                bus.mem_req   = 1'b1;
                bus.busy      = 1'b1;
                addr_mux      = bus.instr_addr;
                bus.instr_ack = bus.mem_ack;
            end
            GRANT_D: begin
                bus.mem_req   = 1'b1;
                bus.busy      = 1'b1;
                bus.mem_we    = bus.data_we;
                addr_mux      = bus.data_addr;
                bus.mem_wdata = bus.data_wdata;
                bus.mem_wstrb = bus.data_we ? bus.data_wstrb : 4'h0;
                bus.data_ack  = bus.mem_ack;
            end
            default: ;
        endcase
    end

    assign bus.mem_addr    = addr_mux;
    assign bus.instr_rdata = bus.mem_rdata;
    assign bus.data_rdata  = bus.mem_rdata;

    // Counts data grants completed while fetch is waiting; saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!bus.instr_req) begin
                        burst_cnt <= '0;
                    end
                end
                GRANT_I: begin
                    if (bus.mem_ack) begin
                        burst_cnt <= '0;
                    end
                end
                GRANT_D: begin
                    if (bus.mem_ack && bus.instr_req) begin
                        burst_cnt <= burst_inc(burst_cnt, BURST_CNT_W'(MAX_DATA_BURST));
                    end
                end
                default: burst_cnt <= '0;
            endcase
        end
    end

endmodule
